// File: rtl/cu_pkg.sv
// Shared control-unit types: register selects, SP ops, load scoreboard entry.
// Helpers map a select to its byte lanes inside one A..L register set.
package cu_pkg;

   localparam int BANK_W = 8;

   typedef enum logic [3:0] {
      SEL_A    = 4'd0,
      SEL_F    = 4'd1,
      SEL_B    = 4'd2,
      SEL_C    = 4'd3,
      SEL_D    = 4'd4,
      SEL_E    = 4'd5,
      SEL_H    = 4'd6,
      SEL_L    = 4'd7,
      SEL_AF   = 4'd8,
      SEL_BC   = 4'd9,
      SEL_DE   = 4'd10,
      SEL_HL   = 4'd11,
      SEL_SP   = 4'd12,
      SEL_PC   = 4'd13,
      SEL_MEM  = 4'd14,
      SEL_NONE = 4'd15
   } reg_sel_t;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_DEC2 = 2'd1,
      SP_INC2 = 2'd2
   } sp_op_t;

   typedef struct packed {
      logic              valid;
      reg_sel_t          sel;
      logic [BANK_W-1:0] bank;
   } sb_entry_t;

   function automatic logic is_af(reg_sel_t s);
      return s inside {SEL_A, SEL_F, SEL_AF};
   endfunction

   function automatic logic is_pair(reg_sel_t s);
      return s inside {SEL_AF, SEL_BC, SEL_DE, SEL_HL};
   endfunction

   // Byte lanes 0..7 = A,F,B,C,D,E,H,L; a pair covers lanes 2p and 2p+1.
   function automatic logic [7:0] sel_mask(reg_sel_t s);
      logic [7:0] m;
      m = '0;
      if (!s[3])
         m = 8'b1 << s[2:0];
      else if (is_pair(s))
         m = 8'b11 << {s[1:0], 1'b0};
      return m;
   endfunction

   function automatic logic [7:0] byte_of(reg_sel_t s, logic [15:0] d,
                                          logic [2:0] k);
      return (is_pair(s) && !k[0]) ? d[15:8] : d[7:0];
   endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// Decoder/ALU/memory/PC-side bundle of the banked register file.
// master = the units driving requests, slave = the register file.
interface banked_register_file_if
   import cu_pkg::*;
#(
   parameter int NUM_RD = 4,
   parameter int BW     = 1
) ();

   logic          wr_en;
   reg_sel_t      wr_sel;
   logic [15:0]   wr_data;
   logic          flag_wr_en;
   logic [7:0]    flag_data;
   sp_op_t        sp_op;
   logic          swap_af;
   logic          swap_main;
   logic          ld_issue;
   reg_sel_t      ld_sel;
   logic          mem_ack;
   logic [15:0]   mem_data;
   reg_sel_t      rd_sel  [NUM_RD];
   logic [15:0]   rd_data [NUM_RD];
   logic          rd_busy [NUM_RD];
   logic [15:0]   pc_i;
   logic          pc_wr_en;
   logic [15:0]   pc_o;
   logic          ld_pending;
   logic          proto_err;
   logic [BW-1:0] bank_af;
   logic [BW-1:0] bank_main;

   modport master (
      output wr_en, wr_sel, wr_data, flag_wr_en, flag_data, sp_op,
             swap_af, swap_main, ld_issue, ld_sel, mem_ack, mem_data,
             rd_sel, pc_i,
      input  rd_data, rd_busy, pc_wr_en, pc_o, ld_pending, proto_err,
             bank_af, bank_main
   );

   modport slave (
      input  wr_en, wr_sel, wr_data, flag_wr_en, flag_data, sp_op,
             swap_af, swap_main, ld_issue, ld_sel, mem_ack, mem_data,
             rd_sel, pc_i,
      output rd_data, rd_busy, pc_wr_en, pc_o, ld_pending, proto_err,
             bank_af, bank_main
   );

endinterface

// File: rtl/reg_bank.sv
// One A,F,B,C,D,E,H,L register set with per-byte write enables.
// Pair writes arrive as two enabled lanes; all lanes are read out.
module reg_bank (
   input  logic            clk,
   input  logic            nrst,
   input  logic [7:0]      we,
   input  logic [7:0][7:0] wd,
   output logic [7:0][7:0] q
);

   logic [7:0][7:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < 8; k++)
         if (we[k]) mem_d[k] = wd[k];
   end

   always_ff @(posedge clk) begin
      if (!nrst) mem_q <= '0;
      else       mem_q <= mem_d;
   end

   assign q = mem_q;

endmodule

// File: rtl/banked_register_file.sv
// Banked A..L register sets with EX AF / EXX pointers, SP, memory latch
// and a single-entry load scoreboard feeding combinational read ports.
module banked_register_file
   import cu_pkg::*;
#(
   parameter int          NUM_BANKS = 2,
   parameter int          NUM_RD    = 4,
   parameter logic [15:0] RESET_SP  = 16'hff00
) (
   input logic                   clk,
   input logic                   nrst,
   banked_register_file_if.slave bus
);

   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [BW-1:0] bank_af_q, bank_af_d;
   logic [BW-1:0] bank_main_q, bank_main_d;
   logic [15:0]   sp_q, sp_d;
   logic [15:0]   mem_q, mem_d;
   sb_entry_t     sb_q, sb_d;
   logic          err_q, err_d;

   logic [NUM_BANKS-1:0][7:0]      we;
   logic [NUM_BANKS-1:0][7:0][7:0] wd;
   logic [NUM_BANKS-1:0][7:0][7:0] regs;

   logic [BW-1:0] wr_bank, ack_bank;
   logic [7:0]    wr_mask, ack_mask, sb_mask;
   logic          ack_hit;
   logic [BW-1:0] rd_bank [NUM_RD];
   logic [7:0]    rd_mask [NUM_RD];

   genvar g;
   generate
      for (g = 0; g < NUM_BANKS; g++) begin : g_bank
         reg_bank u_bank (
            .clk  (clk),
            .nrst (nrst),
            .we   (we[g]),
            .wd   (wd[g]),
            .q    (regs[g])
         );
      end
   endgenerate

   assign ack_hit  = bus.mem_ack && sb_q.valid;
   assign ack_bank = sb_q.bank[BW-1:0];
   assign sb_mask  = sel_mask(sb_q.sel);
   assign ack_mask = ack_hit ? sb_mask : '0;
   assign wr_bank  = is_af(bus.wr_sel) ? bank_af_q : bank_main_q;
   assign wr_mask  = bus.wr_en ? sel_mask(bus.wr_sel) : '0;

   // Load completion is applied last so it wins any byte collision.
   always_comb begin
      we = '0;
      wd = '0;
      for (int k = 0; k < 8; k++)
         if (wr_mask[k]) begin
            we[wr_bank][k] = 1'b1;
            wd[wr_bank][k] = byte_of(bus.wr_sel, bus.wr_data, 3'(k));
         end
      if (bus.flag_wr_en && !wr_mask[1]) begin
         we[bank_af_q][1] = 1'b1;
         wd[bank_af_q][1] = bus.flag_data;
      end
      for (int k = 0; k < 8; k++)
         if (ack_mask[k]) begin
            we[ack_bank][k] = 1'b1;
            wd[ack_bank][k] = byte_of(sb_q.sel, bus.mem_data, 3'(k));
         end
   end

   always_comb begin
      bank_af_d   = bank_af_q;
      bank_main_d = bank_main_q;
      if (bus.swap_af)
         bank_af_d = (NUM_BANKS == 1) ? '0 : bank_af_q + 1'b1;
      if (bus.swap_main)
         bank_main_d = (NUM_BANKS == 1) ? '0 : bank_main_q + 1'b1;

      sp_d = sp_q;
      unique case (bus.sp_op)
         SP_DEC2: sp_d = sp_q - 16'd2;
         SP_INC2: sp_d = sp_q + 16'd2;
         default: sp_d = sp_q;
      endcase
      if (bus.wr_en && bus.wr_sel == SEL_SP) sp_d = bus.wr_data;
      if (ack_hit && sb_q.sel == SEL_SP)     sp_d = bus.mem_data;

      mem_d = bus.mem_ack ? bus.mem_data : mem_q;

      sb_d  = sb_q;
      err_d = err_q;
      if (bus.mem_ack) begin
         if (sb_q.valid) sb_d.valid = 1'b0;
         else            err_d      = 1'b1;
      end
      // An ack in the same cycle frees the slot for the new issue.
      if (bus.ld_issue) begin
         if (sb_q.valid && !bus.mem_ack) begin
            err_d = 1'b1;
         end else begin
            sb_d.valid = 1'b1;
            sb_d.sel   = bus.ld_sel;
            sb_d.bank  = BANK_W'(is_af(bus.ld_sel) ? bank_af_q
                                                   : bank_main_q);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_bank[i] = is_af(bus.rd_sel[i]) ? bank_af_q : bank_main_q;
         rd_mask[i] = sel_mask(bus.rd_sel[i]);
         bus.rd_data[i] = '0;
         unique case (1'b1)
            !bus.rd_sel[i][3]:
               bus.rd_data[i] = {8'h00, regs[rd_bank[i]][bus.rd_sel[i][2:0]]};
            is_pair(bus.rd_sel[i]):
               bus.rd_data[i] = {regs[rd_bank[i]][{bus.rd_sel[i][1:0], 1'b0}],
                                 regs[rd_bank[i]][{bus.rd_sel[i][1:0], 1'b1}]};
            (bus.rd_sel[i] == SEL_SP):  bus.rd_data[i] = sp_q;
            (bus.rd_sel[i] == SEL_PC):  bus.rd_data[i] = bus.pc_i;
            (bus.rd_sel[i] == SEL_MEM): bus.rd_data[i] = mem_q;
            default:                    bus.rd_data[i] = '0;
         endcase
         bus.rd_busy[i] = sb_q.valid &&
            (((|(rd_mask[i] & sb_mask)) &&
              BANK_W'(rd_bank[i]) == sb_q.bank) ||
             (bus.rd_sel[i] == sb_q.sel &&
              bus.rd_sel[i] inside {SEL_SP, SEL_PC, SEL_MEM}));
      end
   end

   always_comb begin
      bus.pc_wr_en = 1'b0;
      bus.pc_o     = '0;
      if (bus.wr_en && bus.wr_sel == SEL_PC) begin
         bus.pc_wr_en = 1'b1;
         bus.pc_o     = bus.wr_data;
      end
      if (ack_hit && sb_q.sel == SEL_PC) begin
         bus.pc_wr_en = 1'b1;
         bus.pc_o     = bus.mem_data;
      end
   end

   assign bus.ld_pending = sb_q.valid;
   assign bus.proto_err  = err_q;
   assign bus.bank_af    = bank_af_q;
   assign bus.bank_main  = bank_main_q;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         bank_af_q   <= '0;
         bank_main_q <= '0;
         sp_q        <= RESET_SP;
         mem_q       <= '0;
         sb_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         bank_af_q   <= bank_af_d;
         bank_main_q <= bank_main_d;
         sp_q        <= sp_d;
         mem_q       <= mem_d;
         sb_q        <= sb_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: vector table plus hand-written
// load, swap, collision and protocol-error sequences.
module tb_banked_register_file;
   import cu_pkg::*;

   logic clk;
   logic nrst;
   int   total;
   int   bad;

   banked_register_file_if #(.NUM_RD(4), .BW(1)) bus ();
   banked_register_file_if #(.NUM_RD(4), .BW(2)) bus4 ();

   banked_register_file #(
      .NUM_BANKS (2),
      .NUM_RD    (4),
      .RESET_SP  (16'hff00)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   banked_register_file #(
      .NUM_BANKS (4),
      .NUM_RD    (4),
      .RESET_SP  (16'hff00)
   ) dut4 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus4)
   );

   typedef struct {
      logic        wr_en;
      reg_sel_t    wr_sel;
      logic [15:0] wr_data;
      logic        fl_en;
      logic [7:0]  fl;
      sp_op_t      sp_op;
      logic        sw_af;
      logic        sw_main;
      reg_sel_t    chk_sel;
      logic [15:0] exp;
   } vec_t;

   localparam int NV = 18;
   vec_t vec [NV];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en      = 1'b0;
      bus.wr_sel     = SEL_NONE;
      bus.wr_data    = '0;
      bus.flag_wr_en = 1'b0;
      bus.flag_data  = '0;
      bus.sp_op      = SP_NONE;
      bus.swap_af    = 1'b0;
      bus.swap_main  = 1'b0;
      bus.ld_issue   = 1'b0;
      bus.ld_sel     = SEL_NONE;
      bus.mem_ack    = 1'b0;
      bus.mem_data   = '0;
      bus.pc_i       = 16'h1234;
      bus4.wr_en      = 1'b0;
      bus4.wr_sel     = SEL_NONE;
      bus4.wr_data    = '0;
      bus4.flag_wr_en = 1'b0;
      bus4.flag_data  = '0;
      bus4.sp_op      = SP_NONE;
      bus4.swap_af    = 1'b0;
      bus4.swap_main  = 1'b0;
      bus4.ld_issue   = 1'b0;
      bus4.ld_sel     = SEL_NONE;
      bus4.mem_ack    = 1'b0;
      bus4.mem_data   = '0;
      bus4.pc_i       = 16'h0000;
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 4; i++) begin
         bus.rd_sel[i]  = SEL_NONE;
         bus4.rd_sel[i] = SEL_NONE;
      end

      vec[0]  = '{1'b1, SEL_A,    16'h9911, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_A,  16'h0011};
      vec[1]  = '{1'b1, SEL_BC,   16'hbeef, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_BC, 16'hbeef};
      vec[2]  = '{1'b1, SEL_C,    16'h7742, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_BC, 16'hbe42};
      vec[3]  = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b1, SEL_BC, 16'h0000};
      vec[4]  = '{1'b1, SEL_HL,   16'h1234, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_H,  16'h0012};
      vec[5]  = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b1, SEL_BC, 16'hbe42};
      vec[6]  = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_HL, 16'h0000};
      vec[7]  = '{1'b1, SEL_AF,   16'ha5c3, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_F,  16'h00c3};
      vec[8]  = '{1'b0, SEL_NONE, 16'h0000, 1'b1, 8'h3c, SP_NONE, 1'b0, 1'b0, SEL_AF, 16'ha53c};
      vec[9]  = '{1'b1, SEL_F,    16'h0077, 1'b1, 8'h3c, SP_NONE, 1'b0, 1'b0, SEL_F,  16'h0077};
      vec[10] = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b1, 1'b0, SEL_A,  16'h0000};
      vec[11] = '{1'b1, SEL_A,    16'h00ee, 1'b0, 8'h00, SP_NONE, 1'b1, 1'b0, SEL_A,  16'h00a5};
      vec[12] = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b1, 1'b0, SEL_A,  16'h00ee};
      vec[13] = '{1'b1, SEL_SP,   16'h0000, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_SP, 16'h0000};
      vec[14] = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_DEC2, 1'b0, 1'b0, SEL_SP, 16'hfffe};
      vec[15] = '{1'b1, SEL_SP,   16'h8000, 1'b0, 8'h00, SP_INC2, 1'b0, 1'b0, SEL_SP, 16'h8000};
      vec[16] = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_INC2, 1'b0, 1'b0, SEL_SP, 16'h8002};
      vec[17] = '{1'b0, SEL_NONE, 16'h0000, 1'b0, 8'h00, SP_NONE, 1'b0, 1'b0, SEL_PC, 16'h1234};

      idle();
      nrst = 1'b0;
      tick();
      tick();
      nrst = 1'b1;
      bus.rd_sel[0] = SEL_SP;
      bus.rd_sel[1] = SEL_A;
      bus.rd_sel[2] = SEL_PC;
      bus.rd_sel[3] = SEL_NONE;
      #1;
      chk("rst_sp",   bus.rd_data[0], 16'hff00);
      chk("rst_a",    bus.rd_data[1], 16'h0000);
      chk("rst_pc",   bus.rd_data[2], 16'h1234);
      chk("rst_none", bus.rd_data[3], 16'h0000);
      chk("rst_busy", 16'({bus.rd_busy[0], bus.rd_busy[1],
                           bus.rd_busy[2], bus.rd_busy[3]}), 16'h0);
      chk("rst_pcwe", 16'(bus.pc_wr_en),   16'h0);
      chk("rst_pco",  bus.pc_o,            16'h0000);
      chk("rst_pend", 16'(bus.ld_pending), 16'h0);
      chk("rst_err",  16'(bus.proto_err),  16'h0);
      chk("rst_baf",  16'(bus.bank_af),    16'h0);
      chk("rst_bmn",  16'(bus.bank_main),  16'h0);

      for (int i = 0; i < NV; i++) begin
         bus.wr_en      = vec[i].wr_en;
         bus.wr_sel     = vec[i].wr_sel;
         bus.wr_data    = vec[i].wr_data;
         bus.flag_wr_en = vec[i].fl_en;
         bus.flag_data  = vec[i].fl;
         bus.sp_op      = vec[i].sp_op;
         bus.swap_af    = vec[i].sw_af;
         bus.swap_main  = vec[i].sw_main;
         tick();
         idle();
         bus.rd_sel[0] = vec[i].chk_sel;
         #1;
         chk($sformatf("vec%0d", i), bus.rd_data[0], vec[i].exp);
      end

      // load to HL, bank swapped away while pending
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_HL;
      tick();
      idle();
      bus.rd_sel[1] = SEL_H;
      #1;
      chk("ld_pend",   16'(bus.ld_pending), 16'h1);
      chk("busy_h",    16'(bus.rd_busy[1]), 16'h1);
      bus.swap_main = 1'b1;
      tick();
      idle();
      #1;
      chk("busy_h_sw", 16'(bus.rd_busy[1]), 16'h0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h5a5a;
      tick();
      idle();
      bus.rd_sel[0] = SEL_HL;
      #1;
      chk("ld_done",   16'(bus.ld_pending), 16'h0);
      chk("hl_newbank", bus.rd_data[0], 16'h1234);
      bus.swap_main = 1'b1;
      tick();
      idle();
      #1;
      chk("hl_loaded", bus.rd_data[0], 16'h5a5a);

      // ALU write and load ack to the same bytes
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_AF;
      tick();
      idle();
      bus.wr_en    = 1'b1;
      bus.wr_sel   = SEL_A;
      bus.wr_data  = 16'h0011;
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h2233;
      tick();
      idle();
      bus.rd_sel[0] = SEL_A;
      bus.rd_sel[1] = SEL_AF;
      #1;
      chk("coll_a",  bus.rd_data[0], 16'h0022);
      chk("coll_af", bus.rd_data[1], 16'h2233);

      // PC writes and loads are combinational
      bus.wr_en   = 1'b1;
      bus.wr_sel  = SEL_PC;
      bus.wr_data = 16'h4321;
      #1;
      chk("pcw_en", 16'(bus.pc_wr_en), 16'h1);
      chk("pcw_o",  bus.pc_o,          16'h4321);
      tick();
      idle();
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_PC;
      tick();
      idle();
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h0100;
      #1;
      chk("pcld_en", 16'(bus.pc_wr_en), 16'h1);
      chk("pcld_o",  bus.pc_o,          16'h0100);
      tick();
      idle();
      #1;
      chk("pc_idle", 16'(bus.pc_wr_en), 16'h0);
      chk("pc_err",  16'(bus.proto_err), 16'h0);

      // issue and ack in the same cycle
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_B;
      tick();
      idle();
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_C;
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h00ab;
      tick();
      idle();
      #1;
      chk("same_pend", 16'(bus.ld_pending), 16'h1);
      chk("same_err",  16'(bus.proto_err),  16'h0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h00cd;
      tick();
      idle();
      bus.rd_sel[0] = SEL_BC;
      #1;
      chk("same_bc",   bus.rd_data[0], 16'habcd);
      chk("same_done", 16'(bus.ld_pending), 16'h0);

      // double issue is a protocol error and sticky
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_A;
      tick();
      idle();
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_B;
      tick();
      idle();
      #1;
      chk("dbl_err", 16'(bus.proto_err), 16'h1);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h0077;
      tick();
      idle();
      bus.rd_sel[0] = SEL_A;
      tick();
      chk("err_sticky", 16'(bus.proto_err), 16'h1);
      chk("dbl_a",      bus.rd_data[0],     16'h0077);

      // reset clears state; reset mid-load drops the entry
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      bus.rd_sel[0] = SEL_SP;
      #1;
      chk("rst2_err", 16'(bus.proto_err), 16'h0);
      chk("rst2_sp",  bus.rd_data[0],     16'hff00);
      chk("rst2_baf", 16'(bus.bank_af),   16'h0);
      bus.ld_issue = 1'b1;
      bus.ld_sel   = SEL_HL;
      tick();
      idle();
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      #1;
      chk("rst_drop", 16'(bus.ld_pending), 16'h0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 16'h1111;
      tick();
      idle();
      #1;
      chk("late_ack", 16'(bus.proto_err), 16'h1);

      // four banks wrap after four swaps
      bus4.wr_en   = 1'b1;
      bus4.wr_sel  = SEL_BC;
      bus4.wr_data = 16'hbeef;
      bus4.rd_sel[0] = SEL_BC;
      tick();
      idle();
      for (int s = 1; s <= 4; s++) begin
         bus4.swap_main = 1'b1;
         tick();
         idle();
         #1;
         chk($sformatf("wrap%0d", s), bus4.rd_data[0],
             (s == 4) ? 16'hbeef : 16'h0000);
      end
      chk("wrap_ptr", 16'(bus4.bank_main), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
